// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch-side initiator for a word-addressed instruction memory with
// combinational read. It owns the PC, presents it as the memory address every
// cycle, and captures each returned word (tagged with its PC) into a small
// prefetch FIFO. Decode drains the FIFO through a valid/ready handshake. A
// redirect pulse from execute flushes the FIFO and restarts fetch at the
// target address.
//
// Parameters
//   RESET_PC    PC loaded on reset (bits [1:0] must be 0)
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2)
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   imem_addr_out     byte address to instruction memory (the PC register)
//   imem_instr_in     instruction word for imem_addr_out, same cycle
//   redirect_in       one-cycle pulse: flush FIFO, load redirect_pc_in
//   redirect_pc_in    redirect target (bits [1:0] forced to 0)
//   fetch_valid_out   FIFO head is valid
//   fetch_ready_in    decode accepts the head this cycle
//   fetch_instr_out   instruction at the FIFO head
//   fetch_pc_out      PC of the instruction at the FIFO head
//   fifo_count_out    occupied FIFO entries
//
// Optional feature, enabled by defining FETCH_PERF_EN:
//   fetched_count_out 32-bit count of words pushed into the FIFO
//   stall_cycles_out  32-bit count of cycles with a valid head not accepted
//
// Handshake: a transfer to decode happens on a rising edge where
// fetch_valid_out and fetch_ready_in are both high. fetch_valid_out does not
// depend on fetch_ready_in, and the head stays stable until it is accepted or
// a redirect flushes it.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [31:0]                   imem_addr_out,
  input  logic [31:0]                   imem_instr_in,
  input  logic                          redirect_in,
  input  logic [31:0]                   redirect_pc_in,
  output logic                          fetch_valid_out,
  input  logic                          fetch_ready_in,
  output logic [31:0]                   fetch_instr_out,
  output logic [31:0]                   fetch_pc_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                   fetched_count_out,
  output logic [31:0]                   stall_cycles_out
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [31:0]      pc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0] pc_mem    [FIFO_DEPTH];
  logic [31:0] instr_mem [FIFO_DEPTH];

  logic pop;
  logic push;

  assign fetch_valid_out = (count != '0);
  assign pop             = fetch_valid_out & fetch_ready_in;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot the tail points at, so the push can proceed into it.
  assign push            = !redirect_in & ((count < DEPTH_C) | pop);

  assign imem_addr_out   = pc;
  assign fifo_count_out  = count;
  // Head is read from registered storage only, never from imem_instr_in.
  assign fetch_instr_out = instr_mem[rd_ptr];
  assign fetch_pc_out    = pc_mem[rd_ptr];

  // PC register: advances only when a word is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_in) begin
      pc <= {redirect_pc_in[31:2], 2'b00};
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  // FIFO storage. Cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= imem_instr_in;
    end
  end

  // Pointers and occupancy. A redirect discards every entry by pulling the
  // read pointer up to the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_in) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters: free-running, wrap at 2^32, untouched by redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_count_out <= '0;
      stall_cycles_out  <= '0;
    end else begin
      if (push) begin
        fetched_count_out <= fetched_count_out + 32'd1;
      end
      if (fetch_valid_out && !fetch_ready_in) begin
        stall_cycles_out <= stall_cycles_out + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. Two instances share clock and
// reset: "dut" (RESET_PC = 0) takes the directed stimulus, "dut_wrap"
// (RESET_PC = 32'hFFFF_FFF8) streams freely to exercise the 32-bit PC wrap.
// The instruction memory is a combinational function of the address.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;

  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic [2:0]  fifo_count;

  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic        w_valid;
  logic [31:0] w_finstr;
  logic [31:0] w_fpc;
  logic [2:0]  w_count;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_count;
  logic [31:0] stall_cycles;
  logic [31:0] w_fetched_count;
  logic [31:0] w_stall_cycles;
`endif

  int vectors;
  int miscompares;

  // ---- clock ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- instruction memory model: word at byte address addr ----
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'hC0DE_0000 ^ (addr >> 2);
  endfunction

  assign imem_instr = mem_word(imem_addr);
  assign w_instr    = mem_word(w_addr);

  // ---- DUTs ----
  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr_out   (imem_addr),
    .imem_instr_in   (imem_instr),
    .redirect_in     (redirect),
    .redirect_pc_in  (redirect_pc),
    .fetch_valid_out (fetch_valid),
    .fetch_ready_in  (fetch_ready),
    .fetch_instr_out (fetch_instr),
    .fetch_pc_out    (fetch_pc),
    .fifo_count_out  (fifo_count)
`ifdef FETCH_PERF_EN
    ,
    .fetched_count_out (fetched_count),
    .stall_cycles_out  (stall_cycles)
`endif
  );

  instruction_fetch_unit #(
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (4)
  ) dut_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr_out   (w_addr),
    .imem_instr_in   (w_instr),
    .redirect_in     (1'b0),
    .redirect_pc_in  (32'h0),
    .fetch_valid_out (w_valid),
    .fetch_ready_in  (1'b1),
    .fetch_instr_out (w_finstr),
    .fetch_pc_out    (w_fpc),
    .fifo_count_out  (w_count)
`ifdef FETCH_PERF_EN
    ,
    .fetched_count_out (w_fetched_count),
    .stall_cycles_out  (w_stall_cycles)
`endif
  );

  // ---- checking ----
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed head PCs for the wrapping instance after reset release.
  logic [31:0] wrap_pcs [5];

  // ---- directed sequence ----
  initial begin
    vectors      = 0;
    miscompares  = 0;
    wrap_pcs[0]  = 32'hFFFF_FFF8;
    wrap_pcs[1]  = 32'hFFFF_FFFC;
    wrap_pcs[2]  = 32'h0000_0000;
    wrap_pcs[3]  = 32'h0000_0004;
    wrap_pcs[4]  = 32'h0000_0008;

    rst_n       = 1'b0;
    fetch_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // 1. Reset state
    step();
    step();
    chk("rst_addr",   imem_addr,           32'h0);
    chk("rst_valid",  {31'b0, fetch_valid}, 32'h0);
    chk("rst_count",  {29'b0, fifo_count},  32'h0);
    chk("rst_instr",  fetch_instr,         32'h0);
    chk("rst_pc",     fetch_pc,            32'h0);
    chk("rst_waddr",  w_addr,              32'hFFFF_FFF8);

    // 2. Streaming with decode always ready; 5. wrap on the second instance
    rst_n       = 1'b1;
    fetch_ready = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("str_valid", {31'b0, fetch_valid}, 32'h1);
      chk("str_pc",    fetch_pc,             32'(4 * k));
      chk("str_instr", fetch_instr,          32'hC0DE_0000 ^ 32'(k));
      chk("str_count", {29'b0, fifo_count},  32'h1);
      chk("wrap_pc",   w_fpc,                wrap_pcs[k]);
      chk("wrap_instr", w_finstr,            mem_word(wrap_pcs[k]));
      step();
    end

    // 3. Backpressure from a fresh reset
    rst_n       = 1'b0;
    fetch_ready = 1'b0;
    #1;
    chk("rst2_count", {29'b0, fifo_count}, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("bp_count", {29'b0, fifo_count}, (i < 4) ? 32'(i) : 32'd4);
    end
    chk("bp_addr",  imem_addr, 32'h10);
    chk("bp_head",  fetch_pc,  32'h0);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", fetched_count, 32'd4);
    chk("perf_stall",   stall_cycles,  32'd9);
`endif
    // Release: full & pop each cycle keeps count at 4 while draining in order.
    fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc",    fetch_pc,    32'(4 * i));
      chk("drain_instr", fetch_instr, 32'hC0DE_0000 ^ 32'(i));
      step();
      chk("drain_count", {29'b0, fifo_count}, 32'd4);
    end
    chk("drain_addr", imem_addr, 32'h20);

    // 4. Redirect with FIFO full
    fetch_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h16;
    step();
    redirect = 1'b0;
    chk("redir_count", {29'b0, fifo_count},  32'h0);
    chk("redir_valid", {31'b0, fetch_valid}, 32'h0);
    chk("redir_addr",  imem_addr,            32'h14);
    step();
    chk("redir_hvalid", {31'b0, fetch_valid}, 32'h1);
    chk("redir_hpc",    fetch_pc,             32'h14);
    chk("redir_hinstr", fetch_instr,          32'hC0DE_0005);
    chk("redir_hcount", {29'b0, fifo_count},  32'h1);

    // Back-to-back redirects: last one wins, nothing pushed in between
    fetch_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    chk("b2b_count1", {29'b0, fifo_count}, 32'h0);
    chk("b2b_addr1",  imem_addr,           32'h100);
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    chk("b2b_count2", {29'b0, fifo_count}, 32'h0);
    chk("b2b_addr2",  imem_addr,           32'h200);
    step();
    chk("b2b_hpc",    fetch_pc,             32'h200);
    chk("b2b_hvalid", {31'b0, fetch_valid}, 32'h1);

    // 6. Reset asserted mid-stream with three entries queued
    rst_n       = 1'b0;
    fetch_ready = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("mid_count3", {29'b0, fifo_count}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", {31'b0, fetch_valid}, 32'h0);
    chk("mid_count", {29'b0, fifo_count},  32'h0);
    chk("mid_addr",  imem_addr,            32'h0);
    chk("mid_instr", fetch_instr,          32'h0);
`ifdef FETCH_PERF_EN
    chk("mid_fetched", fetched_count, 32'h0);
    chk("mid_stall",   stall_cycles,  32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
